// File: rtl/riscv_pkg.sv
// riscv_pkg - shared constants and types for the instruction-fetch slice.
//   XLEN             : machine word width
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC : default fetch address after reset
//   fetch_entry_t    : one fetch-buffer entry {pc, instruction word}
//   pc_inc()         : sequential next-PC helper (wraps modulo 2^XLEN)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
  // Clears the byte-offset bits so every PC stays word aligned.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a word-aligned PC; natural wrap at 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if - bundles the instruction-memory, redirect and decode-side
// handshake signals of the fetch stage.
//   master : fetch stage (drives imem_a and the if_* outputs)
//   slave  : environment (memory, execute redirect, decode ready)
interface ifetch_if import riscv_pkg::*;;

  logic [XLEN-1:0] imem_a;
  logic [XLEN-1:0] imem_rd;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    output imem_a,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_plus4
  );

  modport slave (
    input  imem_a,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4
  );

endinterface

// File: rtl/ifetch_fetch_fifo.sv
// fetch_fifo - small FIFO of fetched {pc, instr} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of all entries (wins over push/pop)
//   push       : write push_data (accepted if not full, or full and popping)
//   pop        : retire head entry (ignored when empty)
//   head_data  : current head entry (undefined when empty; gate with empty)
//   empty/full : occupancy flags, decoded from the registered count
module fetch_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  fetch_entry_t     mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty = (count_r == CNT_W'(0));
  assign full  = (count_r == CNT_W'(DEPTH));

  // Saturating accept: never pop empty, never push full unless a slot frees now.
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Entry storage; contents are only observed through count-qualified reads.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/ifetch.sv
// ifetch - instruction-fetch stage: owns the PC, reads instruction memory
// combinationally and queues {pc, instr} pairs in a fetch buffer for decode.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : ifetch_if.master (imem_a/imem_rd, redirect_valid/redirect_pc,
//                  if_valid/if_ready handshake, if_instr, if_pc, if_pc_plus4)
// Decode-side outputs depend only on fetch-buffer registers.
module ifetch import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  ifetch_if.master bus
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] redirect_tgt_s;
  logic            enq_s;
  logic            deq_s;
  logic            buf_empty_s;
  logic            buf_full_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_entry_s;
  logic            if_valid_s;
  logic [XLEN-1:0] if_instr_s;
  logic [XLEN-1:0] if_pc_s;

  // Masking keeps every PC word aligned regardless of redirect_pc[1:0].
  assign redirect_tgt_s = bus.redirect_pc & PC_ALIGN_MASK;

  // A handshake in a redirect cycle still retires the head; the flush drops the rest.
  assign deq_s = ~buf_empty_s & bus.if_ready;
  assign enq_s = ~bus.redirect_valid & (~buf_full_s | deq_s);

  assign push_entry_s = '{pc: pc_r, instr: bus.imem_rd};
  assign bus.imem_a   = pc_r;

  // Next-PC selection: redirect beats sequential advance, otherwise hold.
  always_comb begin
    pc_next_s = pc_r;
    if (bus.redirect_valid) begin
      pc_next_s = redirect_tgt_s;
    end else if (enq_s) begin
      pc_next_s = pc_inc(pc_r);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r <= RESET_PC & PC_ALIGN_MASK;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (bus.redirect_valid),
    .push      (enq_s),
    .push_data (push_entry_s),
    .pop       (deq_s),
    .head_data (head_entry_s),
    .empty     (buf_empty_s),
    .full      (buf_full_s)
  );

  // Head presentation: an empty buffer shows a NOP at PC 0.
  always_comb begin
    if_valid_s = 1'b0;
    if_instr_s = NOP_INSTR;
    if_pc_s    = 32'h0000_0000;
    if (!buf_empty_s) begin
      if_valid_s = 1'b1;
      if_instr_s = head_entry_s.instr;
      if_pc_s    = head_entry_s.pc;
    end else begin
      if_valid_s = 1'b0;
      if_instr_s = NOP_INSTR;
      if_pc_s    = 32'h0000_0000;
    end
  end

  assign bus.if_valid    = if_valid_s;
  assign bus.if_instr    = if_instr_s;
  assign bus.if_pc       = if_pc_s;
  assign bus.if_pc_plus4 = pc_inc(if_pc_s);

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch - directed, self-checking bench for ifetch. Two instances share
// clock and reset: dut0 with default parameters, dut1 with RESET_PC near the
// top of the address space to exercise PC wrap.
module tb_ifetch;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  ifetch_if bus0 ();
  ifetch_if bus1 ();

  ifetch dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  ifetch #(
    .RESET_PC  (32'hFFFF_FFF8),
    .BUF_DEPTH (2)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  // Instruction memory model: two fixed words, address-derived elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0113;
      32'h0000_0004: return 32'h00C0_0193;
      default:       return {a[23:0], 8'h33};
    endcase
  endfunction

  assign bus0.imem_rd = mem_word(bus0.imem_a);
  assign bus1.imem_rd = mem_word(bus1.imem_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    bus0.if_ready = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc = 32'h0;
    bus1.if_ready = 1'b1;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc = 32'h0;

    // Reset state
    repeat (2) tick();
    check_eq("rst_valid", {31'b0, bus0.if_valid}, 32'h0);
    check_eq("rst_instr", bus0.if_instr, 32'h0000_0013);
    check_eq("rst_pc", bus0.if_pc, 32'h0);
    check_eq("rst_imem_a", bus0.imem_a, 32'h0);
    check_eq("rst_imem_a_d1", bus1.imem_a, 32'hFFFF_FFF8);

    // Release with decode ready: one-cycle latency and 1/cycle throughput
    reset_n = 1'b1;
    bus0.if_ready = 1'b1;
    tick();
    check_eq("c1_valid", {31'b0, bus0.if_valid}, 32'h1);
    check_eq("c1_pc", bus0.if_pc, 32'h0);
    check_eq("c1_instr", bus0.if_instr, 32'h0050_0113);
    check_eq("d1_c1_pc", bus1.if_pc, 32'hFFFF_FFF8);
    check_eq("d1_c1_pc4", bus1.if_pc_plus4, 32'hFFFF_FFFC);
    tick();
    check_eq("c2_pc", bus0.if_pc, 32'h4);
    check_eq("c2_instr", bus0.if_instr, 32'h00C0_0193);
    check_eq("c2_pc4", bus0.if_pc_plus4, 32'h8);
    check_eq("d1_c2_pc", bus1.if_pc, 32'hFFFF_FFFC);
    check_eq("d1_c2_pc4", bus1.if_pc_plus4, 32'h0);
    tick();
    check_eq("c3_pc", bus0.if_pc, 32'h8);
    check_eq("c3_instr", bus0.if_instr, 32'h0000_0833);
    check_eq("d1_c3_pc", bus1.if_pc, 32'h0);

    // Asynchronous reset pulse between edges
    reset_n = 1'b0;
    bus0.if_ready = 1'b0;
    #2;
    check_eq("arst_valid", {31'b0, bus0.if_valid}, 32'h0);
    check_eq("arst_instr", bus0.if_instr, 32'h0000_0013);
    check_eq("arst_pc", bus0.if_pc, 32'h0);
    check_eq("arst_imem_a", bus0.imem_a, 32'h0);
    check_eq("arst_d1_imem_a", bus1.imem_a, 32'hFFFF_FFF8);
    #1;
    reset_n = 1'b1;

    // Restart at RESET_PC with decode stalled: fill, then hold
    tick();
    check_eq("h1_valid", {31'b0, bus0.if_valid}, 32'h1);
    check_eq("h1_pc", bus0.if_pc, 32'h0);
    check_eq("h1_instr", bus0.if_instr, 32'h0050_0113);
    check_eq("h1_imem_a", bus0.imem_a, 32'h4);
    check_eq("d1_restart_pc", bus1.if_pc, 32'hFFFF_FFF8);
    tick();
    check_eq("h2_pc", bus0.if_pc, 32'h0);
    check_eq("h2_imem_a", bus0.imem_a, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_valid", {31'b0, bus0.if_valid}, 32'h1);
      check_eq("hold_pc", bus0.if_pc, 32'h0);
      check_eq("hold_instr", bus0.if_instr, 32'h0050_0113);
      check_eq("hold_imem_a", bus0.imem_a, 32'h8);
    end

    // Drain: no loss, no duplicate; full + dequeue still enqueues
    bus0.if_ready = 1'b1;
    tick();
    check_eq("r1_pc", bus0.if_pc, 32'h4);
    check_eq("r1_instr", bus0.if_instr, 32'h00C0_0193);
    tick();
    check_eq("r2_pc", bus0.if_pc, 32'h8);
    check_eq("r2_instr", bus0.if_instr, 32'h0000_0833);
    tick();
    check_eq("r3_pc", bus0.if_pc, 32'hC);
    check_eq("r3_instr", bus0.if_instr, 32'h0000_0C33);
    check_eq("r3_imem_a", bus0.imem_a, 32'h14);

    // Full, no dequeue: saturate
    bus0.if_ready = 1'b0;
    tick();
    check_eq("sat_pc", bus0.if_pc, 32'hC);
    check_eq("sat_imem_a", bus0.imem_a, 32'h14);

    // Redirect while full
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h40;
    tick();
    check_eq("rd_valid", {31'b0, bus0.if_valid}, 32'h0);
    check_eq("rd_imem_a", bus0.imem_a, 32'h40);
    check_eq("rd_instr", bus0.if_instr, 32'h0000_0013);
    check_eq("rd_pc", bus0.if_pc, 32'h0);
    bus0.redirect_valid = 1'b0;
    tick();
    check_eq("rd2_valid", {31'b0, bus0.if_valid}, 32'h1);
    check_eq("rd2_pc", bus0.if_pc, 32'h40);
    check_eq("rd2_pc4", bus0.if_pc_plus4, 32'h44);
    check_eq("rd2_instr", bus0.if_instr, 32'h0000_4033);

    // Misaligned target and back-to-back redirects, handshake active
    bus0.if_ready = 1'b1;
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h43;
    tick();
    check_eq("mis_imem_a", bus0.imem_a, 32'h40);
    check_eq("mis_valid", {31'b0, bus0.if_valid}, 32'h0);
    bus0.redirect_pc = 32'h101;
    tick();
    check_eq("b2b_imem_a", bus0.imem_a, 32'h100);
    check_eq("b2b_valid", {31'b0, bus0.if_valid}, 32'h0);
    bus0.redirect_valid = 1'b0;
    tick();
    check_eq("b2b_pc", bus0.if_pc, 32'h100);
    check_eq("b2b_instr", bus0.if_instr, 32'h0001_0033);
    tick();
    check_eq("b2b_next_pc", bus0.if_pc, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2: fetch-buffer entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_a  output  32  instruction-memory address, equal to the current PC register.
REQ-006 imem_rd  input  32  instruction word returned combinationally by instruction memory for imem_a.
REQ-007 redirect_valid  input  1  taken branch/jump from execute; flush and redirect.
REQ-008 redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-009 if_valid  output  1  head buffer entry valid toward decode.
REQ-010 if_ready  input  1  decode accepts the head entry this cycle.
REQ-011 if_instr  output  32  instruction word of the head entry.
REQ-012 if_pc  output  32  PC of the head entry.
REQ-013 if_pc_plus4  output  32  if_pc + 4, modulo 2^32.

Function
REQ-014 The PC register shall hold a word-aligned address, with pc[1:0] always 0.
REQ-015 Enqueue shall occur when redirect_valid=0 and the buffer is not full, or when it is full and a dequeue happens in the same cycle; the entry is {pc, imem_rd}.
REQ-016 On each enqueue, pc shall become pc+4, wrapping from 32'hFFFF_FFFC to 32'h0000_0000; otherwise pc shall hold.
REQ-017 Dequeue shall occur when if_valid=1 and if_ready=1; the entry then leaves the buffer in FIFO order.
REQ-018 if_valid, if_instr, if_pc and if_pc_plus4 shall be driven from registered buffer state only, with no combinational path from imem_rd, if_ready or redirect_*.
REQ-019 When if_valid=0, if_instr shall read 32'h0000_0013 (NOP) and if_pc shall read 0.
REQ-020 Latency: an instruction enqueued in cycle N shall be presented on if_valid/if_instr in cycle N+1 if the buffer was empty.
REQ-021 When the buffer is full and if_ready=0, if_valid, if_instr and if_pc shall stay stable, pc shall hold, and imem_rd shall be ignored.
REQ-022 redirect_valid=1 shall take priority over all other events:
- the buffer empties next cycle;
- pc becomes {redirect_pc[31:2],2'b00};
- no enqueue occurs that cycle.
REQ-023 A handshake completing in a redirect cycle shall still count as a transfer; killing it is decode's responsibility.
REQ-024 Back-to-back redirects shall each take effect, the last one winning, with no enqueue until redirect_valid=0.
REQ-025 Entry count shall saturate: no enqueue when full without a dequeue, and no dequeue when empty.
REQ-026 Sustained throughput with if_ready=1 shall be one instruction per cycle.

Reset
REQ-027 On reset_n=0, asynchronously:
- pc = RESET_PC;
- buffer count, read pointer and write pointer = 0;
- if_valid = 0, if_instr = NOP, if_pc = 0.
REQ-028 Reset asserted mid-stream shall discard all buffered entries; the first enqueue after release shall be at RESET_PC in the first clock edge with reset_n=1.

Structure
REQ-029 Shared package riscv_pkg shall hold XLEN=32, the NOP encoding 32'h0000_0013 and the default RESET_PC constant.
REQ-030 The buffer shall be one sub-module, fetch_fifo (parameterised depth, synchronous flush, async active-low reset); ifetch shall own the PC and the next-PC/redirect logic.

Verification
REQ-031 Reset release with memory words 0x00500113 at 0 and 0x00C00193 at 4, if_ready=1 -> cycle 1 shows if_valid=1, if_pc=0, if_instr=0x00500113; cycle 2 shows if_pc=4, if_instr=0x00C00193.
REQ-032 Hold if_ready=0 for 5 cycles -> buffer fills to BUF_DEPTH, pc stalls at 4*BUF_DEPTH, outputs stay stable, and no instruction is lost or duplicated after if_ready=1.
REQ-033 redirect_valid=1 with redirect_pc=0x40 while the buffer is full -> next cycle if_valid=0 and imem_a=0x40; following cycle if_pc=0x40.
REQ-034 redirect_pc=0x43 -> imem_a=0x40.
REQ-035 RESET_PC=32'hFFFF_FFF8 with if_ready=1 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, and if_pc_plus4 for FFFF_FFFC reads 0000_0000.
REQ-036 reset_n pulsed low mid-stream between clock edges -> if_valid drops immediately without waiting for a clock edge, and fetch restarts at RESET_PC.
